syn_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 8-bit `syn_fifo`. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, defined simultaneous read/write behaviour, and sticky overflow/underflow error flags. It sits between a single-clock producer and consumer as a general rate-matching buffer.

---
 rtl/syn_fifo_pkg.sv | 21 ++
 rtl/syn_fifo_ram.sv | 38 +++
 rtl/syn_fifo_param.sv | 113 +++++++++++
 tb/tb_syn_fifo_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/syn_fifo_pkg.sv
// rtl/syn_fifo_pkg.sv - shared width derivation and parameter legality helpers for syn_fifo_param
package syn_fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// rtl/syn_fifo_ram.sv - simple dual-port RAM, synchronous write, registered read
module syn_fifo_ram #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage is deliberately left uninitialised on reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a same-address write lands after the old word is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/syn_fifo_param.sv
// rtl/syn_fifo_param.sv - parametrised synchronous FIFO with occupancy, thresholds and sticky errors
module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 16,
    parameter  int AF_THRESH = DEPTH - 2,
    parameter  int AE_THRESH = 2,
    localparam int ADDR_W    = addr_w(DEPTH),
    localparam int CNT_W     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $fatal(1, "syn_fifo_param: DEPTH must be a power of two >= 2");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $fatal(1, "syn_fifo_param: AF_THRESH/AE_THRESH out of range");
    end
    if (DATA_W < 1) begin : g_bad_width
        $fatal(1, "syn_fifo_param: DATA_W must be >= 1");
    end

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

    // A write into a full FIFO is still legal when a read frees the oldest slot this cycle.
    assign wr_ok = write_en & (~full | read_en);
    assign rd_ok = read_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        // Set after clear so a same-cycle error survives err_clr.
        if (write_en & ~wr_ok) begin
            overflow_d = 1'b1;
        end
        if (read_en & ~rd_ok) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    syn_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_ok & ~reset),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (rd_ok & ~reset),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (out)
    );

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_syn_fifo_param.sv
// tb/tb_syn_fifo_param.sv - scoreboard bench for syn_fifo_param (DEPTH=8, AF=6, AE=1)
module tb_syn_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] data_in = '0;
    logic       err_clr = 1'b0;
    logic [7:0] out;
    logic       full, empty, almost_full, almost_empty;
    logic [3:0] count;
    logic       overflow, underflow;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];
    logic       mon_pending = 1'b0;

    always #5 clk = ~clk;

    syn_fifo_param #(
        .DATA_W    (8),
        .DEPTH     (8),
        .AF_THRESH (6),
        .AE_THRESH (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .read_en      (read_en),
        .data_in      (data_in),
        .err_clr      (err_clr),
        .out          (out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Monitor: a read handshake seen at an edge yields data on out by the following negedge.
    always @(posedge clk) mon_pending <= read_en & ~empty & ~reset;

    always @(negedge clk) begin
        if (mon_pending) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: out=0x%02h but no read data was expected", out);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                if (out !== exp) begin
                    miscompares++;
                    $display("FAIL sb_out: got 0x%02h expected 0x%02h", out, exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic we, input logic re, input logic clr,
                       input logic [7:0] din);
        reset    = rst;
        write_en = we;
        read_en  = re;
        err_clr  = clr;
        data_in  = din;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_out", out, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // Fill 0x01..0x08, then overflow
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 0, 0, 8'(i));
            chk("fill_count", count, i);
            chk("fill_afull", almost_full, (i >= 6));
            chk("fill_full", full, (i == 8));
        end
        cyc(0, 1, 0, 0, 8'h09);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);
        cyc(0, 1, 0, 1, 8'h09);
        chk("ovf_set_wins", overflow, 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("ovf_cleared", overflow, 0);

        // Drain, then underflow
        for (int i = 1; i <= 8; i++) begin
            sb.push_back(8'(i));
            cyc(0, 0, 1, 0, 8'h00);
            chk("drain_count", count, 8 - i);
        end
        chk("drain_empty", empty, 1);
        cyc(0, 0, 1, 0, 8'h00);
        chk("unf_set", underflow, 1);
        chk("unf_out_hold", out, 8'h08);
        cyc(0, 0, 0, 1, 8'h00);
        chk("unf_cleared", underflow, 0);

        // Simultaneous read+write at full
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'(8'h10 + i));
        chk("sim_full_pre", full, 1);
        sb.push_back(8'h10);
        cyc(0, 1, 1, 0, 8'hAA);
        chk("sim_count", count, 8);
        chk("sim_ovf", overflow, 0);
        chk("sim_out", out, 8'h10);
        for (int i = 1; i < 8; i++) sb.push_back(8'(8'h10 + i));
        sb.push_back(8'hAA);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'h00);
        chk("sim_last_out", out, 8'hAA);
        chk("sim_empty", empty, 1);

        // Wrap-around stream: 20 writes, reads lag by three so count stays at 3
        begin
            int rd_next;
            rd_next = 0;
            for (int i = 0; i < 20; i++) begin
                if (i >= 3) begin
                    sb.push_back(8'(rd_next));
                    rd_next++;
                end
                cyc(0, 1, (i >= 3), 0, 8'(i));
                chk("wrap_count", count, (i < 3) ? i + 1 : 3);
            end
            while (rd_next < 20) begin
                sb.push_back(8'(rd_next));
                rd_next++;
                cyc(0, 0, 1, 0, 8'h00);
            end
        end
        chk("wrap_empty", empty, 1);
        chk("wrap_ovf", overflow, 0);
        chk("wrap_unf", underflow, 0);
        chk("wrap_last", out, 8'h13);

        // Mid-stream reset: 4 stored, overflow set, reset with write
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 8'(8'h30 + i));
        cyc(0, 1, 0, 0, 8'h38);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(8'(8'h30 + i));
            cyc(0, 0, 1, 0, 8'h00);
        end
        chk("mid_count_pre", count, 4);
        chk("mid_ovf_pre", overflow, 1);
        cyc(1, 1, 0, 0, 8'h55);
        chk("mid_count", count, 0);
        chk("mid_empty", empty, 1);
        chk("mid_ovf", overflow, 0);
        chk("mid_unf", underflow, 0);
        chk("mid_out", out, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        chk("mid_write_ignored", underflow, 1);
        chk("mid_out_hold", out, 8'h00);

        cyc(0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
